// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move sequencer: cell codes,
// FSM states, winner codes and the eight win lines.
package ttt_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;
    localparam int BOARD_W   = 2 * NUM_CELLS;
    localparam int TIMER_W   = 16;

    typedef logic [1:0] cell_t;

    localparam cell_t EMPTY = 2'b00;
    localparam cell_t P1    = 2'b01;
    localparam cell_t P2    = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [1:0] TURN_NONE = 2'b00;
    localparam logic [1:0] TURN_P1   = 2'b01;
    localparam logic [1:0] TURN_P2   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        P1_TURN,
        P1_CHECK,
        P2_TURN,
        P2_CHECK,
        DONE
    } state_t;

    // Rows, then columns, then the two diagonals; cells are row-major 0..8.
    localparam int WIN_LINES [NUM_LINES][3] = '{
        '{0, 1, 2},
        '{3, 4, 5},
        '{6, 7, 8},
        '{0, 3, 6},
        '{1, 4, 7},
        '{2, 5, 8},
        '{0, 4, 8},
        '{2, 4, 6}
    };

    function automatic cell_t cell_at(input logic [BOARD_W-1:0] board, input int idx);
        return board[2*idx +: 2];
    endfunction

endpackage

// File: rtl/ttt_move_sequencer_line_check.sv
// Combinational board evaluator: reports a completed line, its owner, and
// whether every cell is occupied.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    output logic               line_win,
    output logic [1:0]         line_owner,
    output logic               full
);

    always_comb begin
        // NOTE: every output gets a default first, so no path through this block can infer a latch.
        line_win   = 1'b0;
        line_owner = EMPTY;
        full       = 1'b1;

        for (int c = 0; c < NUM_CELLS; c++) begin
            if (cell_at(board, c) == EMPTY) begin
                full = 1'b0;
            end
        end

        // First matching line wins; only the last mover can have completed one.
        for (int l = 0; l < NUM_LINES; l++) begin
            if (!line_win
                && cell_at(board, WIN_LINES[l][0]) != EMPTY
                && cell_at(board, WIN_LINES[l][0]) == cell_at(board, WIN_LINES[l][1])
                && cell_at(board, WIN_LINES[l][1]) == cell_at(board, WIN_LINES[l][2])) begin
                line_win   = 1'b1;
                line_owner = cell_at(board, WIN_LINES[l][0]);
            end
        end
    end

endmodule

// File: rtl/ttt_move_sequencer.sv
// Tic-tac-toe move sequencer: owns the board, alternates turns over a
// valid/ready handshake, enforces a per-turn timeout and detects win/draw.
module ttt_move_sequencer
    import ttt_pkg::*;
#(
    parameter int unsigned TURN_TIMEOUT = 1024
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               p1_valid,
    input  logic [3:0]         p1_pos,
    output logic               p1_ready,
    input  logic               p2_valid,
    input  logic [3:0]         p2_pos,
    output logic               p2_ready,
    output logic [BOARD_W-1:0] board,
    output logic [1:0]         turn,
    output logic               illegal,
    output logic               timeout,
    output logic               win,
    output logic               no_space,
    output logic [1:0]         winner
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TURN_TIMEOUT - 1);

    state_t               state_q,    state_d;
    logic [BOARD_W-1:0]   board_q,    board_d;
    logic [TIMER_W-1:0]   timer_q,    timer_d;
    logic [1:0]           turn_q,     turn_d;
    logic [1:0]           winner_q,   winner_d;
    logic                 p1_ready_q, p1_ready_d;
    logic                 p2_ready_q, p2_ready_d;
    logic                 illegal_q,  illegal_d;
    logic                 timeout_q,  timeout_d;
    logic                 win_q,      win_d;
    logic                 no_space_q, no_space_d;

    logic                 line_win;
    logic [1:0]           line_owner;
    logic                 full;

    logic                 mover_is_p1;
    logic                 mv_valid;
    logic [3:0]           mv_pos;
    cell_t                mv_code;
    cell_t                target;
    logic                 mv_in_range;

    ttt_line_check u_line_check (
        .board      (board_q),
        .line_win   (line_win),
        .line_owner (line_owner),
        .full       (full)
    );

    // Decode the move of whichever player currently owns the turn.
    always_comb begin
        mover_is_p1 = (state_q == P1_TURN) || (state_q == P1_CHECK);
        mv_valid    = mover_is_p1 ? p1_valid : p2_valid;
        mv_pos      = mover_is_p1 ? p1_pos   : p2_pos;
        mv_code     = mover_is_p1 ? P1       : P2;
        mv_in_range = (mv_pos <= 4'd8);
        target      = EMPTY;
        for (int c = 0; c < NUM_CELLS; c++) begin
            if (mv_pos == 4'(c)) begin
                target = cell_at(board_q, c);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        timer_d    = timer_q;
        win_d      = win_q;
        no_space_d = no_space_q;
        winner_d   = winner_q;
        illegal_d  = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = P1_TURN;
                    board_d    = '0;
                    timer_d    = '0;
                    win_d      = 1'b0;
                    no_space_d = 1'b0;
                    winner_d   = WIN_NONE;
                end
            end

            P1_TURN, P2_TURN: begin
                if (mv_valid) begin
                    timer_d = '0;
                    if (!mv_in_range || target != EMPTY) begin
                        illegal_d = 1'b1;
                    end else begin
                        for (int c = 0; c < NUM_CELLS; c++) begin
                            if (mv_pos == 4'(c)) begin
                                board_d[2*c +: 2] = mv_code;
                            end
                        end
                        state_d = mover_is_p1 ? P1_CHECK : P2_CHECK;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    // Acceptance takes priority, so expiry only fires without a request.
                    timeout_d = 1'b1;
                    timer_d   = '0;
                    state_d   = mover_is_p1 ? P2_TURN : P1_TURN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            P1_CHECK, P2_CHECK: begin
                if (line_win) begin
                    state_d  = DONE;
                    win_d    = 1'b1;
                    winner_d = line_owner;
                end else if (full) begin
                    state_d    = DONE;
                    no_space_d = 1'b1;
                    winner_d   = WIN_DRAW;
                end else begin
                    state_d = mover_is_p1 ? P2_TURN : P1_TURN;
                    timer_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Readies and turn are derived from the next state so they line up with state_q.
        p1_ready_d = (state_d == P1_TURN);
        p2_ready_d = (state_d == P2_TURN);
        unique case (state_d)
            P1_TURN, P1_CHECK: turn_d = TURN_P1;
            P2_TURN, P2_CHECK: turn_d = TURN_P2;
            default:           turn_d = TURN_NONE;
        endcase
    end

    // NOTE: non-blocking assignments, so every flop samples the pre-edge value of every other.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            // NOTE: the board is cleared by reset because the FSM reads it, unlike a scratch memory.
            board_q    <= '0;
            timer_q    <= '0;
            turn_q     <= TURN_NONE;
            winner_q   <= WIN_NONE;
            p1_ready_q <= 1'b0;
            p2_ready_q <= 1'b0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
            win_q      <= 1'b0;
            no_space_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            timer_q    <= timer_d;
            turn_q     <= turn_d;
            winner_q   <= winner_d;
            p1_ready_q <= p1_ready_d;
            p2_ready_q <= p2_ready_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
            win_q      <= win_d;
            no_space_q <= no_space_d;
        end
    end

    assign board    = board_q;
    assign turn     = turn_q;
    assign winner   = winner_q;
    assign p1_ready = p1_ready_q;
    assign p2_ready = p2_ready_q;
    assign illegal  = illegal_q;
    assign timeout  = timeout_q;
    assign win      = win_q;
    assign no_space = no_space_q;

endmodule
